// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter
//   Read-side adapter for a synchronous FIFO with a fixed 1-cycle read latency.
//   Read strobes are issued from the FIFO level and a local credit count. The
//   returning data lands in a small skid buffer, which is presented to the
//   consumer as a valid/ready stream. Because of the credit check, consumer
//   back-pressure can never overflow the buffer or underflow the FIFO.
//
// Ports
//   i_clk            clock, all state on rising edge
//   i_rst            synchronous reset, active-high
//   i_fifo_level     FIFO occupancy, registered inside the FIFO
//   o_fifo_rden      read strobe to the FIFO
//   i_fifo_data      FIFO read data
//   i_fifo_data_vld  FIFO read data valid, one cycle after o_fifo_rden
//   o_m_data         stream data (skid buffer head)
//   o_m_valid        stream valid
//   i_m_ready        stream ready
//   o_err_spurious   sticky: data returned with no read in flight
//   o_err_missing    sticky: read in flight but no data returned
//   o_beat_cnt       delivered beats (wrapping), stats build only
//   o_stall_cnt      valid & ~ready cycles (saturating), stats build only
//
// Build option
//   RD_ADPT_STATS_EN  when defined, the beat/stall counters are built;
//                     otherwise both counter ports are tied to 0.

module fifo_rd_adapter #(
  parameter int DATA_WIDTH = 64,
  parameter int LEVEL_W    = 5,
  parameter int BUF_DEPTH  = 4,
  parameter int BUF_LOG2   = $clog2(BUF_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [LEVEL_W-1:0]    i_fifo_level,
  output logic                  o_fifo_rden,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_data_vld,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_err_spurious,
  output logic                  o_err_missing,
  output logic [31:0]           o_beat_cnt,
  output logic [31:0]           o_stall_cnt
);

  // occupancy needs one extra bit to represent a completely full buffer
  localparam int                OCC_W   = BUF_LOG2 + 1;
  localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [BUF_LOG2-1:0]   r_wr_ptr;
  logic [BUF_LOG2-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_inflight;
  logic                  r_err_spurious;
  logic                  r_err_missing;

  logic [OCC_W-1:0]      w_used;
  logic                  w_rden;
  logic                  w_push;
  logic                  w_valid;
  logic                  w_pop;

  // A read in flight already owns a buffer slot, so it counts against credit.
  assign w_used  = r_occ + OCC_W'(r_inflight);
  assign w_rden  = ~i_rst & (i_fifo_level != '0) & (w_used < DEPTH_C);

  // Data without a matching read is discarded, never written.
  assign w_push  = i_fifo_data_vld & r_inflight;
  assign w_valid = (r_occ != '0);
  assign w_pop   = w_valid & i_m_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_occ          <= '0;
      r_inflight     <= 1'b0;
      r_err_spurious <= 1'b0;
      r_err_missing  <= 1'b0;
      // cleared so the head reads 0 straight after reset
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_inflight <= w_rden;

      if (w_push) begin
        r_buf[r_wr_ptr] <= i_fifo_data;
        r_wr_ptr        <= r_wr_ptr + BUF_LOG2'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + BUF_LOG2'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase

      if (i_fifo_data_vld & ~r_inflight) begin
        r_err_spurious <= 1'b1;
      end
      // A missing return frees its credit implicitly: r_inflight drops anyway.
      if (r_inflight & ~i_fifo_data_vld) begin
        r_err_missing <= 1'b1;
      end
    end
  end

  assign o_fifo_rden    = w_rden;
  assign o_m_valid      = w_valid;
  assign o_m_data       = r_buf[r_rd_ptr];
  assign o_err_spurious = r_err_spurious;
  assign o_err_missing  = r_err_missing;

`ifdef RD_ADPT_STATS_EN
  logic [31:0] r_beat_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end
      if (w_valid & ~i_m_ready & (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_beat_cnt  = r_beat_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_beat_cnt  = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
module tb_fifo_rd_adapter;

  logic        clk;
  logic        i_rst;
  logic [4:0]  fifo_lvl;
  logic        o_fifo_rden;
  logic [63:0] i_fifo_data;
  logic        i_fifo_data_vld;
  logic [63:0] o_m_data;
  logic        o_m_valid;
  logic        i_m_ready;
  logic        o_err_spurious;
  logic        o_err_missing;
  logic [31:0] o_beat_cnt;
  logic [31:0] o_stall_cnt;

  int checks;
  int failures;

  // upstream FIFO model state
  logic [63:0] next_val;
  bit          suppress_vld;
  bit          inject_vld;

  // per-cycle observations (sampled at the falling edge)
  bit          last_rden;
  bit          last_valid;
  logic [63:0] last_data;
  logic [63:0] rx_q[$];
  int          rden_cnt;
  int          stall_exp;

  fifo_rd_adapter dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_fifo_level   (fifo_lvl),
    .o_fifo_rden    (o_fifo_rden),
    .i_fifo_data    (i_fifo_data),
    .i_fifo_data_vld(i_fifo_data_vld),
    .o_m_data       (o_m_data),
    .o_m_valid      (o_m_valid),
    .i_m_ready      (i_m_ready),
    .o_err_spurious (o_err_spurious),
    .o_err_missing  (o_err_missing),
    .o_beat_cnt     (o_beat_cnt),
    .o_stall_cnt    (o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: observe at negedge, then after the rising edge apply the
  // FIFO's response (level decrement and 1-cycle-late read data).
  task automatic tick();
    bit s_rden;
    @(negedge clk);
    s_rden     = o_fifo_rden;
    last_rden  = o_fifo_rden;
    last_valid = o_m_valid;
    last_data  = o_m_data;
    if (o_m_valid && i_m_ready) rx_q.push_back(o_m_data);
    if (o_m_valid && !i_m_ready) stall_exp++;
    if (o_fifo_rden) rden_cnt++;
    @(posedge clk);
    #1;
    if (s_rden && fifo_lvl != 0) begin
      fifo_lvl        = fifo_lvl - 5'd1;
      i_fifo_data_vld = !suppress_vld;
      i_fifo_data     = next_val;
      next_val        = next_val + 64'd1;
    end else begin
      i_fifo_data_vld = inject_vld;
      i_fifo_data     = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    inject_vld = 1'b0;
  endtask

  task automatic do_reset();
    i_rst        = 1'b1;
    suppress_vld = 1'b0;
    inject_vld   = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    rx_q.delete();
    rden_cnt  = 0;
    stall_exp = 0;
  endtask

  task automatic test_reset();
    bit exp_rden [6] = '{1, 1, 1, 0, 0, 0};
    bit exp_vld  [6] = '{0, 0, 1, 1, 1, 0};
    int bad;
    fifo_lvl  = 5'd3;
    i_m_ready = 1'b1;
    next_val  = 64'h1000;
    i_rst     = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (o_m_valid !== 1'b0 || o_m_data !== 64'd0 || o_fifo_rden !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h rden=%b required 0/0/0", o_m_valid, o_m_data, o_fifo_rden);
    end
    checks++;
    if (o_err_spurious !== 1'b0 || o_err_missing !== 1'b0) begin
      failures++;
      $display("FAIL reset_errs: spurious=%b missing=%b required 0/0", o_err_spurious, o_err_missing);
    end
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    rx_q.delete();
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (last_rden !== exp_rden[c] || last_valid !== exp_vld[c]) begin
        bad++;
        $display("cycle %0d: rden=%b valid=%b required %b/%b", c, last_rden, last_valid, exp_rden[c], exp_vld[c]);
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL startup_timing: %0d bad cycles required 0", bad);
    end
    checks++;
    if (rx_q.size() !== 3 || rx_q[0] !== 64'h1000 || rx_q[1] !== 64'h1001 || rx_q[2] !== 64'h1002) begin
      failures++;
      $display("FAIL startup_data: got %0d beats required D0..D2 (0x1000..0x1002)", rx_q.size());
    end
    checks++;
    if (o_err_spurious !== 1'b0 || o_err_missing !== 1'b0) begin
      failures++;
      $display("FAIL startup_errs: spurious=%b missing=%b required 0/0", o_err_spurious, o_err_missing);
    end
  endtask

  task automatic test_backpressure();
    int unstable;
    int ticks;
    int bad;
    fifo_lvl = 5'd0;
    do_reset();
    fifo_lvl  = 5'd10;
    next_val  = 64'h2000;
    i_m_ready = 1'b0;
    unstable  = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (last_valid && last_data !== 64'h2000) unstable++;
    end
    checks++;
    if (rden_cnt !== 4) begin
      failures++;
      $display("FAIL full_rden_count: %0d pulses required 4", rden_cnt);
    end
    checks++;
    if (last_valid !== 1'b1 || last_rden !== 1'b0 || unstable !== 0) begin
      failures++;
      $display("FAIL full_hold: valid=%b rden=%b unstable=%0d required 1/0/0", last_valid, last_rden, unstable);
    end
    i_m_ready = 1'b1;
    ticks = 0;
    while (rx_q.size() < 10 && ticks < 60) begin
      tick();
      ticks++;
    end
    checks++;
    if (ticks !== 10) begin
      failures++;
      $display("FAIL drain_back_to_back: %0d cycles for %0d beats required 10 for 10", ticks, rx_q.size());
    end
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i] !== 64'h2000 + 64'(i)) bad++;
    end
    checks++;
    if (bad !== 0 || rx_q.size() !== 10) begin
      failures++;
      $display("FAIL drain_order: %0d out of order, %0d beats required 0 and 10", bad, rx_q.size());
    end
  endtask

  task automatic test_empty_fifo();
    int vld_seen;
    fifo_lvl  = 5'd0;
    i_m_ready = 1'b1;
    tick();
    tick();
    rden_cnt = 0;
    vld_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (last_valid) vld_seen++;
    end
    checks++;
    if (rden_cnt !== 0 || vld_seen !== 0) begin
      failures++;
      $display("FAIL empty_fifo: rden=%0d valid=%0d cycles required 0/0", rden_cnt, vld_seen);
    end
  endtask

  task automatic test_toggle_ready();
    int ticks;
    int bad;
    int max_out;
    fifo_lvl = 5'd0;
    do_reset();
    fifo_lvl  = 5'd16;
    next_val  = 64'h3000;
    i_m_ready = 1'b1;
    ticks     = 0;
    max_out   = 0;
    while (rx_q.size() < 16 && ticks < 150) begin
      tick();
      if (rden_cnt - rx_q.size() > max_out) max_out = rden_cnt - rx_q.size();
      i_m_ready = ~i_m_ready;
      ticks++;
    end
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i] !== 64'h3000 + 64'(i)) bad++;
    end
    checks++;
    if (rx_q.size() !== 16 || bad !== 0) begin
      failures++;
      $display("FAIL toggle_delivery: %0d beats %0d out of order required 16 and 0", rx_q.size(), bad);
    end
    checks++;
    if (max_out > 4) begin
      failures++;
      $display("FAIL toggle_occupancy: max outstanding %0d required <= 4", max_out);
    end
    i_m_ready = 1'b1;
    @(negedge clk);
`ifdef RD_ADPT_STATS_EN
    checks++;
    if (o_beat_cnt !== 32'd16) begin
      failures++;
      $display("FAIL beat_cnt: %0d required 16", o_beat_cnt);
    end
    checks++;
    if (o_stall_cnt !== 32'(stall_exp)) begin
      failures++;
      $display("FAIL stall_cnt: %0d required %0d", o_stall_cnt, stall_exp);
    end
`else
    checks++;
    if (o_beat_cnt !== 32'd0 || o_stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL stats_tied: beat=%0d stall=%0d required 0/0", o_beat_cnt, o_stall_cnt);
    end
`endif
  endtask

  task automatic test_errors();
    fifo_lvl = 5'd0;
    do_reset();
    i_m_ready  = 1'b1;
    inject_vld = 1'b1;
    tick();
    tick();
    checks++;
    if (o_err_spurious !== 1'b1 || o_err_missing !== 1'b0) begin
      failures++;
      $display("FAIL spurious_flag: spurious=%b missing=%b required 1/0", o_err_spurious, o_err_missing);
    end
    checks++;
    if (o_m_valid !== 1'b0) begin
      failures++;
      $display("FAIL spurious_dropped: valid=%b required 0", o_m_valid);
    end
    fifo_lvl     = 5'd1;
    next_val     = 64'h4000;
    suppress_vld = 1'b1;
    tick();
    tick();
    suppress_vld = 1'b0;
    checks++;
    if (o_err_missing !== 1'b1 || o_m_valid !== 1'b0) begin
      failures++;
      $display("FAIL missing_flag: missing=%b valid=%b required 1/0", o_err_missing, o_m_valid);
    end
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (o_err_spurious !== 1'b1 || o_err_missing !== 1'b1) begin
      failures++;
      $display("FAIL errs_sticky: spurious=%b missing=%b required 1/1", o_err_spurious, o_err_missing);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (o_err_spurious !== 1'b0 || o_err_missing !== 1'b0) begin
      failures++;
      $display("FAIL errs_cleared: spurious=%b missing=%b required 0/0", o_err_spurious, o_err_missing);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int ticks;
    fifo_lvl = 5'd0;
    do_reset();
    fifo_lvl  = 5'd10;
    next_val  = 64'h5000;
    i_m_ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    // now 3 beats buffered and one read returning this cycle
    checks++;
    if (i_fifo_data_vld !== 1'b1 || o_m_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_setup: data_vld=%b valid=%b required 1/1", i_fifo_data_vld, o_m_valid);
    end
    i_rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (o_m_valid !== 1'b0 || o_m_data !== 64'd0 || o_fifo_rden !== 1'b0) begin
      failures++;
      $display("FAIL midrst_flush: valid=%b data=%h rden=%b required 0/0/0", o_m_valid, o_m_data, o_fifo_rden);
    end
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    rx_q.delete();
    i_m_ready = 1'b1;
    ticks = 0;
    while (rx_q.size() < 6 && ticks < 40) begin
      tick();
      ticks++;
    end
    checks++;
    if (rx_q.size() !== 6 || rx_q[0] !== 64'h5004 || rx_q[5] !== 64'h5009) begin
      failures++;
      $display("FAIL midrst_resume: %0d beats required 6 starting at 0x5004", rx_q.size());
    end
    checks++;
    if (o_err_spurious !== 1'b0 || o_err_missing !== 1'b0) begin
      failures++;
      $display("FAIL midrst_errs: spurious=%b missing=%b required 0/0", o_err_spurious, o_err_missing);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    i_rst           = 1'b1;
    fifo_lvl        = 5'd0;
    i_fifo_data     = 64'd0;
    i_fifo_data_vld = 1'b0;
    i_m_ready       = 1'b0;
    suppress_vld    = 1'b0;
    inject_vld      = 1'b0;
    next_val        = 64'd0;
    rden_cnt        = 0;
    stall_exp       = 0;
    test_reset();
    test_backpressure();
    test_empty_fifo();
    test_toggle_ready();
    test_errors();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_adapter.md
Name: fifo_rd_adapter

Overview:
Downstream neighbour of the sync FIFO. Issues read strobes into the FIFO based on its level and absorbs the fixed 1-cycle read latency in a small local skid buffer. Presents the data as a valid/ready stream to the consumer, so consumer back-pressure never causes FIFO underflow or lost beats. Flags read-protocol errors with sticky bits.

Parameters:
DATA_WIDTH, 64, width of FIFO data and stream data
LEVEL_W, 5, width of FIFO level input (covers 0..ENTRIES)
BUF_DEPTH, 4, skid buffer entries; power of two, >= 3
BUF_LOG2, $clog2(BUF_DEPTH), skid pointer width

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_fifo_level  in  LEVEL_W  FIFO occupancy; registered in FIFO, updated on the same edge that samples o_fifo_rden
o_fifo_rden  out  1  read strobe to FIFO
i_fifo_data  in  DATA_WIDTH  FIFO read data, valid with i_fifo_data_vld
i_fifo_data_vld  in  1  FIFO read data valid, exactly 1 cycle after o_fifo_rden
o_m_data  out  DATA_WIDTH  stream data
o_m_valid  out  1  stream valid
i_m_ready  in  1  stream ready
o_err_spurious  out  1  sticky: data_vld with no read in flight
o_err_missing  out  1  sticky: read in flight, no data_vld returned
o_beat_cnt  out  32  stats (optional feature)
o_stall_cnt  out  32  stats (optional feature)

Behaviour:
- Reset (i_rst=1 at edge): occ=0, wr/rd ptrs=0, inflight=0, both err bits=0, counters=0. Outputs during/after reset: o_fifo_rden=0, o_m_valid=0, o_m_data=0 (buffer contents don't care, but head reads 0 after reset), errs=0. Reset mid-transfer drops buffered beats and any read in flight.
- o_fifo_rden = ~i_rst & (i_fifo_level != 0) & (occ + inflight < BUF_DEPTH). Depends only on registered state and i_fifo_level; no combinational path from i_m_ready.
- inflight <= o_fifo_rden each cycle (at most 1 outstanding read).
- Capture: i_fifo_data_vld & inflight -> write i_fifo_data at wr_ptr, wr_ptr+1 (wraps mod BUF_DEPTH).
- Stream: o_m_valid = (occ != 0); o_m_data = buf[rd_ptr]. Pop on o_m_valid & i_m_ready, rd_ptr+1 (wraps).
- occ next = occ + push - pop. Simultaneous push/pop keeps occ; push into empty buffer appears on o_m_valid the next cycle (no bypass).
- Latency: level != 0 with empty buffer in cycle N -> rden in N -> data_vld in N+1 -> o_m_valid in N+2.
- Throughput: with i_m_ready held 1 and level >= 1, one beat per cycle sustained (BUF_DEPTH >= 3 covers the credit loop).
- Full: occ + inflight == BUF_DEPTH -> rden held 0 and level untouched; resumes the cycle after a pop frees a credit.
- Empty FIFO (level == 0): no rden issued, so the FIFO never underflows.
- Errors: i_fifo_data_vld & ~inflight -> o_err_spurious=1 and data discarded. inflight & ~i_fifo_data_vld -> o_err_missing=1 and credit released. Both bits clear only on reset.
- Stream rule: once o_m_valid=1, o_m_data is held stable until the pop.

Optional Feature:
Macro RD_ADPT_STATS_EN.
- Defined: o_beat_cnt increments on every pop (32-bit, wraps). o_stall_cnt increments each cycle with o_m_valid & ~i_m_ready (saturates at 32'hFFFF_FFFF). Both clear on reset.
- Undefined: the counter logic is not built. Ports stay present, tied to 0.

Test Plan:
- Reset with level=3, then release; i_m_ready=1 -> rden in cycles 0,1,2; o_m_valid in cycles 2,3,4 carrying D0,D1,D2 in order; no errors.
- Level held 10, i_m_ready=0 -> exactly 4 rden pulses, then rden=0; o_m_valid=1 with D0 stable. Set ready=1 -> 10 beats delivered in order, back-to-back.
- Level=0 for 20 cycles -> rden never asserts, o_m_valid=0.
- Ready toggling 1010..., 16 beats -> all 16 delivered in order, occ never exceeds 4. With RD_ADPT_STATS_EN: o_beat_cnt=16, o_stall_cnt equals count of valid&~ready cycles.
- Inject data_vld with no prior rden -> o_err_spurious=1 next cycle, beat dropped. Suppress data_vld after an rden -> o_err_missing=1; both stay 1 until reset.
- Assert i_rst with 3 beats buffered and 1 in flight -> next cycle o_m_valid=0 and occ=0; after release, normal operation resumes from empty.
